seven_seg_scan_regfile: RTL and testbench

//  Parametrised segment-code register file: DEPTH entries of WIDTH bits, one sync write port, one comb read port.

---
 rtl/seven_seg_scan_regfile.sv | 100 ++++++++++
 tb/tb_seven_seg_scan_regfile.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_regfile.sv
// Segment-code register file with a built-in multiplexed 7-segment scanner.
// One synchronous write port, one combinational read port, registered SEG/DIG/TICK.
module seven_seg_scan_regfile #(
   parameter int WIDTH     = 7,
   parameter int DEPTH     = 16,
   parameter int AW        = 4,
   parameter int DIGITS    = 4,
   parameter int PRESCALE  = 1000,
   parameter int BLINK_DIV = 256
) (
   input  logic              CLK,
   input  logic              CLRN,
   input  logic              WE,
   input  logic [AW-1:0]     WA,
   input  logic [WIDTH-1:0]  WD,
   input  logic [AW-1:0]     RA,
   output logic [WIDTH-1:0]  RDATA,
   input  logic              SCAN_EN,
   input  logic [AW-1:0]     BASE,
   input  logic [DIGITS-1:0] BLINK,
   output logic [WIDTH-1:0]  SEG,
   output logic [DIGITS-1:0] DIG,
   output logic              TICK
);

   localparam int PW = $clog2(PRESCALE);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
   localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);
   localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    presc;
   logic [IW-1:0]    idx;
   logic [BW-1:0]    blk_cnt;
   logic             phase;
   logic             wrap;
   logic             blank;
   logic [AW:0]      sum;
   logic [AW-1:0]    slot_addr;

   // Addresses at or beyond DEPTH never touch storage, so nothing can alias.
   always_ff @(posedge CLK or negedge CLRN) begin
      if (!CLRN) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (WE && ({1'b0, WA} < DEPTH_W)) begin
         mem[WA] <= WD;
      end
   end

   assign RDATA = ({1'b0, RA} < DEPTH_W) ? mem[RA] : '0;

   // The scan window wraps around DEPTH, not around the address space.
   always_comb begin
      sum       = {1'b0, BASE} + (AW + 1)'(idx);
      slot_addr = AW'(sum % DEPTH_W);
   end

   assign wrap  = (presc == PRE_MAX);
   assign blank = phase && BLINK[idx];

   always_ff @(posedge CLK or negedge CLRN) begin
      if (!CLRN) begin
         presc   <= '0;
         idx     <= '0;
         blk_cnt <= '0;
         phase   <= 1'b0;
         SEG     <= '0;
         DIG     <= '0;
         TICK    <= 1'b0;
      end else if (!SCAN_EN) begin
         presc   <= '0;
         idx     <= '0;
         blk_cnt <= '0;
         phase   <= 1'b0;
         SEG     <= '0;
         DIG     <= '0;
         TICK    <= 1'b0;
      end else begin
         presc <= wrap ? '0 : presc + 1'b1;
         TICK  <= wrap;
         if (wrap) begin
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            if (blk_cnt == BLK_MAX) begin
               blk_cnt <= '0;
               phase   <= ~phase;
            end else begin
               blk_cnt <= blk_cnt + 1'b1;
            end
         end
         // Outputs follow the pre-edge idx, so they lag idx by one cycle.
         DIG <= DIGITS'(1) << idx;
         SEG <= blank ? '0 : mem[slot_addr];
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_regfile.sv
// Directed bench for seven_seg_scan_regfile: read-back table, scan/blink model,
// and hand-written sequences for write-while-displayed, SCAN_EN fall on wrap and async reset.
module tb_seven_seg_scan_regfile;

   localparam int AW = 5;
   localparam int W  = 7;
   localparam int D  = 4;

   logic          CLK = 1'b0;
   logic          CLRN = 1'b0;
   logic          WE = 1'b0;
   logic [AW-1:0] WA = '0;
   logic [W-1:0]  WD = '0;
   logic [AW-1:0] RA = '0;
   logic [W-1:0]  RDATA;
   logic          SCAN_EN = 1'b0;
   logic [AW-1:0] BASE = '0;
   logic [D-1:0]  BLINK = '0;
   logic [W-1:0]  SEG;
   logic [D-1:0]  DIG;
   logic          TICK;

   seven_seg_scan_regfile #(
      .WIDTH(W), .DEPTH(16), .AW(AW), .DIGITS(D), .PRESCALE(4), .BLINK_DIV(1)
   ) dut (
      .CLK(CLK), .CLRN(CLRN), .WE(WE), .WA(WA), .WD(WD), .RA(RA), .RDATA(RDATA),
      .SCAN_EN(SCAN_EN), .BASE(BASE), .BLINK(BLINK), .SEG(SEG), .DIG(DIG), .TICK(TICK)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] model_mem [16];
   logic [11:0]  exp_q [$];

   typedef struct {
      logic [AW-1:0] ra;
      logic [W-1:0]  exp;
   } rd_vec_t;
   rd_vec_t rd_vecs [20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] addr, input logic [W-1:0] data);
      WE = 1'b1;
      WA = addr;
      WD = data;
      step();
      WE = 1'b0;
      if (addr < 16) model_mem[addr] = data;
   endtask

   // Restart the scanner and compare {TICK,DIG,SEG} against the model for n cycles.
   task automatic run_scan(input logic [AW-1:0] base, input logic [D-1:0] blink, input int n);
      logic [11:0] e;
      logic [11:0] got;
      int s, d;
      logic ph;
      logic [D-1:0] e_dig;
      logic [W-1:0] e_seg;
      SCAN_EN = 1'b0;
      BASE    = base;
      BLINK   = blink;
      step();
      SCAN_EN = 1'b1;
      for (int k = 1; k <= n; k++) begin
         step();
         s     = (k - 1) / 4;
         d     = s % 4;
         ph    = (s % 2) == 1;
         e_dig = D'(1) << d;
         e_seg = (ph && blink[d]) ? '0 : model_mem[(int'(base) + d) % 16];
         exp_q.push_back({(k % 4 == 0), e_dig, e_seg});
         e   = exp_q.pop_front();
         got = {TICK, DIG, SEG};
         check("scan", 32'(got), 32'(e));
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) model_mem[i] = '0;

      // Reset state without any clock edge.
      #1;
      check("reset_seg", 32'(SEG), 0);
      check("reset_dig", 32'(DIG), 0);
      check("reset_tick", 32'(TICK), 0);
      check("reset_rdata", 32'(RDATA), 0);
      #2;
      CLRN = 1'b1;
      step();

      // Fill all entries, then try out-of-range writes.
      for (int a = 0; a < 16; a++) wr(AW'(a), W'(a + 'h40));
      wr(AW'(16), 7'h7F);
      wr(AW'(31), 7'h7E);

      for (int a = 0; a < 16; a++) rd_vecs[a] = '{AW'(a), W'(a + 'h40)};
      rd_vecs[16] = '{AW'(12), 7'h4C};
      rd_vecs[17] = '{AW'(13), 7'h4D};
      rd_vecs[18] = '{AW'(16), 7'h00};
      rd_vecs[19] = '{AW'(31), 7'h00};
      for (int v = 0; v < 20; v++) begin
         RA = rd_vecs[v].ra;
         #1;
         check("read", 32'(RDATA), 32'(rd_vecs[v].exp));
      end

      // Plain scan across the DEPTH boundary, then blinking over two passes.
      run_scan(AW'(14), 4'b0000, 20);
      run_scan(AW'(0), 4'b0110, 32);

      // Write to the displayed entry while digit 0 is active.
      SCAN_EN = 1'b0;
      BASE    = AW'(3);
      BLINK   = '0;
      step();
      SCAN_EN = 1'b1;
      step();
      check("wdisp_seg_e1", 32'(SEG), 32'h43);
      check("wdisp_dig_e1", 32'(DIG), 32'b0001);
      wr(AW'(3), 7'h11);
      check("wdisp_seg_e2", 32'(SEG), 32'h43);
      step();
      check("wdisp_seg_e3", 32'(SEG), 32'h11);
      wr(AW'(16), 7'h22);
      check("wdisp_seg_e4", 32'(SEG), 32'h11);
      check("wdisp_dig_e4", 32'(DIG), 32'b0001);
      check("wdisp_tick_e4", 32'(TICK), 1);
      RA = AW'(0);
      #1;
      check("no_alias_ra0", 32'(RDATA), 32'h40);
      RA = AW'(16);
      #1;
      check("oor_ra16", 32'(RDATA), 0);

      // SCAN_EN falls exactly on the wrap edge.
      SCAN_EN = 1'b0;
      BASE    = AW'(14);
      step();
      SCAN_EN = 1'b1;
      step();
      step();
      step();
      SCAN_EN = 1'b0;
      step();
      check("fall_seg", 32'(SEG), 0);
      check("fall_dig", 32'(DIG), 0);
      check("fall_tick", 32'(TICK), 0);
      SCAN_EN = 1'b1;
      step();
      check("reen_dig", 32'(DIG), 32'b0001);
      check("reen_seg", 32'(SEG), 32'(model_mem[14]));
      check("reen_tick", 32'(TICK), 0);
      step();
      step();
      step();
      check("reen_tick_wrap", 32'(TICK), 1);
      check("reen_dig_wrap", 32'(DIG), 32'b0001);

      // Asynchronous reset in the middle of a scan.
      step();
      step();
      RA   = AW'(0);
      CLRN = 1'b0;
      #1;
      check("areset_seg", 32'(SEG), 0);
      check("areset_dig", 32'(DIG), 0);
      check("areset_tick", 32'(TICK), 0);
      check("areset_rdata", 32'(RDATA), 0);
      RA = AW'(3);
      #1;
      check("areset_rdata3", 32'(RDATA), 0);
      CLRN = 1'b1;
      step();
      check("post_reset_dig", 32'(DIG), 32'b0001);
      check("post_reset_seg", 32'(SEG), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
